// File: rtl/uart_tx_engine.sv
// uart_tx_engine: framed asynchronous serial transmitter.
// One accepted load sends an 11 bit-time character on tx.
module uart_tx_engine #(
  parameter int KW = 19
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [7:0]    out_port,
  input  logic [KW-1:0] k,
  input  logic          eight,
  input  logic          pen,
  input  logic          ohel,
  output logic          tx,
  output logic          txrdy
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t        r_state;
  logic [10:0]   r_sr;
  logic [3:0]    r_bitcnt;
  logic [KW-1:0] r_pcnt;
  logic [KW-1:0] r_k;
  logic          r_tx;
  logic          r_txrdy;

  logic [7:0]    w_data;
  logic          w_par;
  logic          w_b8;
  logic          w_b9;
  logic [10:0]   w_frame;
  logic [KW-1:0] w_kmax;
  logic          w_wrap;

  // Format flags are folded into the frame at load time, so the
  // shift register is the only per-frame copy they need.
  assign w_data  = eight ? out_port : {1'b0, out_port[6:0]};
  assign w_par   = (^w_data) ^ ohel;
  assign w_b8    = eight ? out_port[7] : (pen ? w_par : 1'b1);
  assign w_b9    = (eight & pen) ? w_par : 1'b1;
  assign w_frame = {1'b1, w_b9, w_b8, out_port[6:0], 1'b0};

  // Divisors below 2 are clamped to 2.
  assign w_kmax  = (r_k < KW'(2)) ? KW'(2) : r_k;
  assign w_wrap  = (r_pcnt == (w_kmax - KW'(1)));

  // Transmit FSM: accept a load in IDLE, shift out 11 bits in SHIFT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_sr     <= '1;
      r_bitcnt <= '0;
      r_pcnt   <= '0;
      r_k      <= '0;
      r_tx     <= 1'b1;
      r_txrdy  <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (load && r_txrdy) begin
            r_state  <= SHIFT;
            r_sr     <= w_frame;
            r_k      <= k;
            r_bitcnt <= '0;
            r_pcnt   <= '0;
            r_tx     <= 1'b0;
            r_txrdy  <= 1'b0;
          end
        end
        SHIFT: begin
          if (w_wrap) begin
            r_pcnt <= '0;
            if (r_bitcnt == 4'd10) begin
              r_state  <= IDLE;
              r_sr     <= '1;
              r_bitcnt <= '0;
              r_tx     <= 1'b1;
              r_txrdy  <= 1'b1;
            end else begin
              r_sr     <= {1'b1, r_sr[10:1]};
              r_tx     <= r_sr[1];
              r_bitcnt <= r_bitcnt + 4'd1;
            end
          end else begin
            r_pcnt <= r_pcnt + KW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx    = r_tx;
  assign txrdy = r_txrdy;

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed plus random frames checked
// bit-by-bit against a queue-built frame model.
module tb_uart_tx_engine;

  localparam int KW = 19;

  logic          clk = 1'b0;
  logic          reset;
  logic          load;
  logic [7:0]    out_port;
  logic [KW-1:0] k;
  logic          eight;
  logic          pen;
  logic          ohel;
  logic          tx;
  logic          txrdy;

  int total = 0;
  int bad   = 0;

  uart_tx_engine #(.KW(KW)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .out_port (out_port),
    .k        (k),
    .eight    (eight),
    .pen      (pen),
    .ohel     (ohel),
    .tx       (tx),
    .txrdy    (txrdy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  // Line image of one character: start, data LSB first,
  // optional parity, then mark up to 11 bit-times.
  function automatic logic [10:0] model_frame(
    input logic [7:0] d, input logic e,
    input logic p, input logic o);
    bit q[$];
    int n;
    int ones;
    logic [10:0] f;
    n = e ? 8 : 7;
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (p) q.push_back(((ones + int'(o)) % 2) == 1);
    while (q.size() < 11) q.push_back(1'b1);
    for (int i = 0; i < 11; i++) f[i] = q[i];
    return f;
  endfunction

  task automatic scramble;
    out_port = 8'($urandom);
    k        = KW'($urandom_range(0, 30));
    eight    = 1'($urandom);
    pen      = 1'($urandom);
    ohel     = 1'($urandom);
  endtask

  // Load one byte, then check every cycle of the frame.
  // ign1/ign2: edges (relative to E0) carrying an extra load.
  // abort: cycle index at which reset is pulsed.
  task automatic send(input logic [7:0] d, input int kk,
                      input logic e, input logic p,
                      input logic o, input int ign1,
                      input int ign2, input int abort);
    logic [10:0] f;
    int kq;
    out_port = d;
    k        = KW'(kk);
    eight    = e;
    pen      = p;
    ohel     = o;
    load     = 1'b1;
    tick();
    load = 1'b0;
    f  = model_frame(d, e, p, o);
    kq = (kk < 2) ? 2 : kk;
    for (int c = 0; c < 11 * kq; c++) begin
      chk("tx_bit", tx, f[c / kq]);
      chk("txrdy_busy", txrdy, 1'b0);
      if (c == abort) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_tx", tx, 1'b1);
        chk("abort_txrdy", txrdy, 1'b1);
        return;
      end
      scramble();
      load = (c == ign1 - 1) || (c == ign2 - 1);
      if (load) out_port = 8'hFF;
      tick();
    end
    load = 1'b0;
    chk("end_tx", tx, 1'b1);
    chk("end_txrdy", txrdy, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_tx", tx, 1'b1);
      chk("idle_txrdy", txrdy, 1'b1);
    end
  endtask

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    out_port = 8'h00;
    k        = '0;
    eight    = 1'b1;
    pen      = 1'b0;
    ohel     = 1'b0;

    for (int i = 0; i < 3; i++) begin
      load     = 1'b1;
      out_port = 8'($urandom);
      k        = KW'(4);
      tick();
      chk("rst_tx", tx, 1'b1);
      chk("rst_txrdy", txrdy, 1'b1);
    end
    reset = 1'b0;
    load  = 1'b0;
    idle(4);

    send(8'hA5, 4, 1'b1, 1'b1, 1'b0, -1, -1, -1);
    idle(2);
    send(8'hC1, 4, 1'b0, 1'b1, 1'b1, -1, -1, -1);
    idle(2);
    send(8'h00, 3, 1'b1, 1'b0, 1'b0, 5, 33, -1);
    send(8'h3C, 3, 1'b1, 1'b1, 1'b1, -1, -1, -1);
    idle(2);
    send(8'h55, 0, 1'b1, 1'b0, 1'b0, -1, -1, -1);
    idle(1);
    send(8'h96, 1, 1'b0, 1'b0, 1'b0, -1, -1, -1);
    idle(1);
    send(8'h5A, 4, 1'b1, 1'b1, 1'b0, -1, -1, 17);
    send(8'h81, 4, 1'b1, 1'b1, 1'b1, -1, -1, -1);
    idle(1);

    for (int n = 0; n < 12; n++) begin
      send(8'($urandom), int'($urandom_range(0, 8)),
           1'($urandom), 1'($urandom), 1'($urandom),
           -1, -1, -1);
      idle(int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
